// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: ALU control decode, operand-B select, 2-entry skid buffer toward the ALU.
// Define ALU_ISSUE_FWD_EN to add the fwd_valid/fwd_idx/fwd_data operand-forwarding inputs.
module alu_issue_stage #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           aluop,
  input  logic [5:0]           funct,
  input  logic                 alusrc,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [4:0]           rs_idx,
  input  logic [4:0]           rt_idx,
`ifdef ALU_ISSUE_FWD_EN
  input  logic                 fwd_valid,
  input  logic [4:0]           fwd_idx,
  input  logic [WIDTH-1:0]     fwd_data,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           operation,
  output logic [WIDTH-1:0]     data_a,
  output logic [WIDTH-1:0]     data_b,
  output logic                 illegal
);

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ill;
  } entry_t;

  entry_t           new_entry;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;

  always_comb begin
    new_entry.op  = 4'b0010;
    new_entry.ill = 1'b0;
    unique case (aluop)
      2'b00: new_entry.op = 4'b0010;
      2'b01: new_entry.op = 4'b0110;
      2'b11: new_entry.op = 4'b0001;
      default: begin
        case (funct)
          6'b100000: new_entry.op = 4'b0010;
          6'b100010: new_entry.op = 4'b0110;
          6'b100100: new_entry.op = 4'b0000;
          6'b100101: new_entry.op = 4'b0001;
          6'b100111: new_entry.op = 4'b1100;
          6'b101010: new_entry.op = 4'b0111;
          default: begin
            new_entry.op  = 4'b0010;
            new_entry.ill = 1'b1;
          end
        endcase
      end
    endcase

    src_a = rs_data;
    src_b = rt_data;
`ifdef ALU_ISSUE_FWD_EN
    // Forwarding only overrides the register path; an immediate operand B is never replaced.
    if (fwd_valid && (fwd_idx != 5'd0)) begin
      if (rs_idx == fwd_idx) src_a = fwd_data;
      if (rt_idx == fwd_idx) src_b = fwd_data;
    end
`endif
    new_entry.a = src_a;
    new_entry.b = alusrc ? {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm} : src_b;
  end

`ifndef ALU_ISSUE_FWD_EN
  logic unused_idx;
  assign unused_idx = ^{rs_idx, rt_idx};
`endif

  assign accept = in_valid && in_ready_q;
  assign pop    = (count_q != 2'd0) && out_ready;

  // Head entry drives the ALU directly; it is left untouched on drain so outputs hold when empty.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (accept) begin
            head_d  = new_entry;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            head_d = new_entry;
          end else if (accept) begin
            tail_d  = new_entry;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      head_q.op  <= 4'b0010;
      head_q.a   <= '0;
      head_q.b   <= '0;
      head_q.ill <= 1'b0;
      tail_q     <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign operation = head_q.op;
  assign data_a    = head_q.a;
  assign data_b    = head_q.b;
  assign illegal   = head_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a reference model pushes expected ops into a queue on
// accept and the queue head is compared against the ALU-side outputs every cycle.
module tb_alu_issue_stage;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic        alusrc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
`ifdef ALU_ISSUE_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] fwd_data;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  operation;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        illegal;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic exp_in_ready;

  alu_issue_stage #(.WIDTH(32), .IMM_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .alusrc(alusrc),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .rs_idx(rs_idx), .rt_idx(rt_idx),
`ifdef ALU_ISSUE_FWD_EN
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .operation(operation), .data_a(data_a), .data_b(data_b), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t        e;
    logic [31:0] ra;
    logic [31:0] rb;
    ra = rs_data;
    rb = rt_data;
`ifdef ALU_ISSUE_FWD_EN
    if (fwd_valid && fwd_idx != 0 && rs_idx == fwd_idx) ra = fwd_data;
    if (fwd_valid && fwd_idx != 0 && rt_idx == fwd_idx) rb = fwd_data;
`endif
    e.ill = 1'b0;
    case ({aluop, funct}) inside
      {2'b00, 6'b??????}:  e.op = 4'b0010;
      {2'b01, 6'b??????}:  e.op = 4'b0110;
      {2'b11, 6'b??????}:  e.op = 4'b0001;
      {2'b10, 6'b100000}:  e.op = 4'b0010;
      {2'b10, 6'b100010}:  e.op = 4'b0110;
      {2'b10, 6'b100100}:  e.op = 4'b0000;
      {2'b10, 6'b100101}:  e.op = 4'b0001;
      {2'b10, 6'b100111}:  e.op = 4'b1100;
      {2'b10, 6'b101010}:  e.op = 4'b0111;
      default: begin
        e.op  = 4'b0010;
        e.ill = 1'b1;
      end
    endcase
    e.a = ra;
    e.b = alusrc ? 32'($signed(imm)) : rb;
    return e;
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] fn,
                               input logic src, input logic [31:0] a, input logic [31:0] b,
                               input logic [15:0] im);
    in_valid = v;
    aluop    = op;
    funct    = fn;
    alusrc   = src;
    rs_data  = a;
    rt_data  = b;
    imm      = im;
  endtask

  // Compare the pre-edge state, clock once, then advance the model and settle on the falling edge.
  task automatic step_cycle();
    logic acc;
    logic pp;
    exp_t e;
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready});
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
    if (sb.size() != 0) begin
      checkOutput("head_op", {28'b0, operation}, {28'b0, sb[0].op});
      checkOutput("head_a", data_a, sb[0].a);
      checkOutput("head_b", data_b, sb[0].b);
      checkOutput("head_ill", {31'b0, illegal}, {31'b0, sb[0].ill});
    end
    acc = in_valid && exp_in_ready;
    pp  = (sb.size() != 0) && out_ready;
    e   = model();
    @(posedge clk);
    if (flush) begin
      sb.delete();
    end else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(e);
    end
    exp_in_ready = flush ? 1'b1 : (sb.size() < 2);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] functs[6];
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    rs_idx    = 5'd0;
    rt_idx    = 5'd0;
`ifdef ALU_ISSUE_FWD_EN
    fwd_valid = 1'b0;
    fwd_idx   = 5'd0;
    fwd_data  = 32'd0;
`endif
    applyStimulus(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    exp_in_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_op", {28'b0, operation}, 32'h2);
    checkOutput("rst_a", data_a, 32'd0);
    checkOutput("rst_b", data_b, 32'd0);
    checkOutput("rst_ill", {31'b0, illegal}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] sub decode");
    applyStimulus(1'b1, 2'b10, 6'b100010, 1'b0, 32'd7, 32'd3, 16'd0);
    step_cycle();
    applyStimulus(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    checkOutput("sub_op", {28'b0, operation}, 32'h6);
    checkOutput("sub_a", data_a, 32'd7);
    checkOutput("sub_b", data_b, 32'd3);
    step_cycle();

    $display("[TB] immediate and illegal funct");
    applyStimulus(1'b1, 2'b00, 6'd0, 1'b1, 32'h100, 32'h55, 16'hFFFC);
    step_cycle();
    checkOutput("imm_b", data_b, 32'hFFFFFFFC);
    applyStimulus(1'b1, 2'b10, 6'b111111, 1'b0, 32'h11, 32'h22, 16'h0);
    step_cycle();
    checkOutput("ill_flag", {31'b0, illegal}, 32'd1);
    checkOutput("ill_op", {28'b0, operation}, 32'h2);
    applyStimulus(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    step_cycle();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 6'd0, 1'b0, 32'hA0, 32'hA1, 16'h0);
    step_cycle();
    applyStimulus(1'b1, 2'b11, 6'd0, 1'b1, 32'hB0, 32'hB1, 16'h7FFF);
    step_cycle();
    applyStimulus(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    checkOutput("bp_full", {31'b0, in_ready}, 32'd0);
    repeat (3) step_cycle();
    checkOutput("bp_hold_a", data_a, 32'hA0);
    out_ready = 1'b1;
    repeat (3) step_cycle();
    checkOutput("bp_ready_back", {31'b0, in_ready}, 32'd1);

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) begin
      if (i < 6) applyStimulus(1'b1, 2'b10, functs[i], 1'b0, $urandom, $urandom, 16'h0);
      else applyStimulus(1'b1, 2'(i - 6), 6'd0, 1'(i), $urandom, $urandom, 16'($urandom));
      step_cycle();
      checkOutput("stream_ready", {31'b0, in_ready}, 32'd1);
    end
    applyStimulus(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    step_cycle();
    step_cycle();

    $display("[TB] flush");
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 6'd0, 1'b0, 32'hC0, 32'hC1, 16'h0);
    repeat (2) step_cycle();
    flush = 1'b1;
    applyStimulus(1'b1, 2'b01, 6'd0, 1'b0, 32'hC2, 32'hC3, 16'h0);
    step_cycle();
    flush = 1'b0;
    applyStimulus(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush_ready", {31'b0, in_ready}, 32'd1);
    step_cycle();
    applyStimulus(1'b1, 2'b11, 6'd0, 1'b0, 32'hD0, 32'hD1, 16'h0);
    step_cycle();
    flush     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b01, 6'd0, 1'b0, 32'hE0, 32'hE1, 16'h0);
    step_cycle();
    flush = 1'b0;
    applyStimulus(1'b1, 2'b10, 6'b100100, 1'b0, 32'hF0, 32'hF1, 16'h0);
    step_cycle();
    applyStimulus(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    checkOutput("post_flush_a", data_a, 32'hF0);
    step_cycle();

    $display("[TB] async reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 6'd0, 1'b0, 32'h123, 32'h456, 16'h0);
    repeat (2) step_cycle();
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("arst_op", {28'b0, operation}, 32'h2);
    checkOutput("arst_a", data_a, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_in_ready = 1'b1;
    out_ready    = 1'b1;
    applyStimulus(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    step_cycle();

`ifdef ALU_ISSUE_FWD_EN
    $display("[TB] forwarding");
    fwd_valid = 1'b1;
    fwd_idx   = 5'd5;
    fwd_data  = 32'd9;
    rs_idx    = 5'd5;
    rt_idx    = 5'd6;
    applyStimulus(1'b1, 2'b00, 6'd0, 1'b0, 32'd1, 32'd2, 16'h0);
    step_cycle();
    checkOutput("fwd_a", data_a, 32'd9);
    checkOutput("fwd_b_none", data_b, 32'd2);
    rt_idx = 5'd5;
    step_cycle();
    checkOutput("fwd_both_b", data_b, 32'd9);
    alusrc = 1'b1;
    imm    = 16'h0004;
    step_cycle();
    checkOutput("fwd_imm_b", data_b, 32'd4);
    fwd_idx = 5'd0;
    rs_idx  = 5'd0;
    alusrc  = 1'b0;
    step_cycle();
    checkOutput("fwd_zero_a", data_a, 32'd1);
    fwd_valid = 1'b0;
    applyStimulus(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
    step_cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
